// File: rtl/inst_fetcher_pkg.sv
// Shared widths, constants and the instruction-queue entry layout for the fetch stage.
package inst_fetcher_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [DATA_WIDTH-1:0] ZERO_DATA = '0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
    logic                  taken;
  } queue_entry_t;

  localparam int unsigned INST_QUEUE_WIDTH = $bits(queue_entry_t);

endpackage

// File: rtl/inst_queue.sv
// Synchronous FIFO holding fetched instructions; flush empties it in one cycle.
module inst_queue
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = INST_QUEUE_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [Width-1:0]       wdata_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      if (push_ok && !pop_ok) count_q <= count_q + CntW'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/inst_fetcher.sv
// Fetch stage: one outstanding memory read at a time, result reported to pc, then queued
// with its prediction bit for the decoder. Rollback flushes everything in flight.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_rollback,
  input  logic [DATA_WIDTH-1:0] in_pc_next_pc,
  input  logic                  in_pc_next_taken,
  output logic                  out_pc_fetcher_ena,
  output logic [DATA_WIDTH-1:0] out_pc_last_pc,
  output logic [DATA_WIDTH-1:0] out_pc_last_inst,
  output logic                  out_mem_req,
  output logic [DATA_WIDTH-1:0] out_mem_addr,
  input  logic                  in_mem_ready,
  input  logic [DATA_WIDTH-1:0] in_mem_data,
  output logic                  out_inst_valid,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [DATA_WIDTH-1:0] out_inst_pc,
  output logic                  out_inst_taken,
  input  logic                  in_decoder_ready
);

  localparam int unsigned CntW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {StIssue, StWait, StSettle} state_e;

  state_e                state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  fetcher_ena_q, fetcher_ena_d;
  logic [DATA_WIDTH-1:0] last_pc_q, last_pc_d;
  logic [DATA_WIDTH-1:0] last_inst_q, last_inst_d;

  logic                  q_push, q_pop, q_flush, q_empty, q_full;
  logic [CntW-1:0]       q_count;
  queue_entry_t          push_entry, head_entry;
  logic [INST_QUEUE_WIDTH-1:0] q_rdata;

  assign push_entry = '{inst: last_inst_q, pc: last_pc_q, taken: in_pc_next_taken};
  assign head_entry = queue_entry_t'(q_rdata);

  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    fetcher_ena_d = fetcher_ena_q;
    last_pc_d     = last_pc_q;
    last_inst_d   = last_inst_q;
    q_push        = FALSE;
    q_pop         = FALSE;
    q_flush       = FALSE;

    if (in_rollback) begin
      q_flush       = TRUE;
      mem_req_d     = FALSE;
      fetcher_ena_d = FALSE;
      state_d       = StIssue;
    end else if (ena) begin
      q_pop = !q_empty && in_decoder_ready;
      unique case (state_q)
        StIssue: begin
          // Reserving a slot here means the push two states later cannot overflow.
          if (q_count < DepthCnt) begin
            mem_req_d  = TRUE;
            mem_addr_d = in_pc_next_pc;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (in_mem_ready) begin
            mem_req_d     = FALSE;
            last_pc_d     = mem_addr_q;
            last_inst_d   = in_mem_data;
            fetcher_ena_d = TRUE;
            state_d       = StSettle;
          end
        end
        StSettle: begin
          // pc presents the prediction for last_pc during this cycle.
          q_push        = !q_full || q_pop;
          fetcher_ena_d = FALSE;
          state_d       = StIssue;
        end
        default: state_d = StIssue;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIssue;
      mem_req_q     <= FALSE;
      mem_addr_q    <= ZERO_DATA;
      fetcher_ena_q <= FALSE;
      last_pc_q     <= ZERO_DATA;
      last_inst_q   <= ZERO_DATA;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      fetcher_ena_q <= fetcher_ena_d;
      last_pc_q     <= last_pc_d;
      last_inst_q   <= last_inst_d;
    end
  end

  inst_queue #(
    .Depth(QUEUE_DEPTH),
    .Width(INST_QUEUE_WIDTH)
  ) u_inst_queue (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (q_push),
    .pop_i  (q_pop),
    .flush_i(q_flush),
    .wdata_i(push_entry),
    .rdata_o(q_rdata),
    .empty_o(q_empty),
    .full_o (q_full),
    .count_o(q_count)
  );

  assign out_pc_fetcher_ena = fetcher_ena_q;
  assign out_pc_last_pc     = last_pc_q;
  assign out_pc_last_inst   = last_inst_q;
  assign out_mem_req        = mem_req_q;
  assign out_mem_addr       = mem_addr_q;

  // Head fields read as zero while empty so stale storage never leaks out.
  assign out_inst_valid = !q_empty;
  assign out_inst       = q_empty ? ZERO_DATA : head_entry.inst;
  assign out_inst_pc    = q_empty ? ZERO_DATA : head_entry.pc;
  assign out_inst_taken = q_empty ? FALSE : head_entry.taken;

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized bench for inst_fetcher against a transaction-level model built on an SV queue.
module tb_inst_fetcher;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, ena, in_rollback, in_pc_next_taken, in_mem_ready, in_decoder_ready;
  logic [31:0] in_pc_next_pc, in_mem_data;
  logic        out_pc_fetcher_ena, out_mem_req, out_inst_valid, out_inst_taken;
  logic [31:0] out_pc_last_pc, out_pc_last_inst, out_mem_addr, out_inst, out_inst_pc;

  always #5 clk = ~clk;

  inst_fetcher #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .rst               (rst),
    .ena               (ena),
    .in_rollback       (in_rollback),
    .in_pc_next_pc     (in_pc_next_pc),
    .in_pc_next_taken  (in_pc_next_taken),
    .out_pc_fetcher_ena(out_pc_fetcher_ena),
    .out_pc_last_pc    (out_pc_last_pc),
    .out_pc_last_inst  (out_pc_last_inst),
    .out_mem_req       (out_mem_req),
    .out_mem_addr      (out_mem_addr),
    .in_mem_ready      (in_mem_ready),
    .in_mem_data       (in_mem_data),
    .out_inst_valid    (out_inst_valid),
    .out_inst          (out_inst),
    .out_inst_pc       (out_inst_pc),
    .out_inst_taken    (out_inst_taken),
    .in_decoder_ready  (in_decoder_ready)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        taken;
  } ent_t;

  // Reference state: what the spec says should be visible on the outputs.
  ent_t        exp_q[$];
  logic        m_req = 1'b0, m_fe = 1'b0;
  logic [31:0] m_addr = '0, m_last_pc = '0, m_last_inst = '0;

  int          errors = 0, checks = 0, cyc = 0;
  int          dec_pct, rb_pct, ena_low_pct, lat = 3, mem_cnt = 0, fe_cnt = 0, last_rise = -1;
  bit          fixed_lat, rb_on_ready, rand_pc, rand_taken, force_rb, spacing_chk;
  logic        prev_req = 1'b0;
  logic [31:0] pc_reg = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    check_eq("mem_req", 32'(out_mem_req), 32'(m_req));
    check_eq("mem_addr", out_mem_addr, m_addr);
    check_eq("fetcher_ena", 32'(out_pc_fetcher_ena), 32'(m_fe));
    check_eq("last_pc", out_pc_last_pc, m_last_pc);
    check_eq("last_inst", out_pc_last_inst, m_last_inst);
    check_eq("inst_valid", 32'(out_inst_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check_eq("head_inst", out_inst, exp_q[0].inst);
      check_eq("head_pc", out_inst_pc, exp_q[0].pc);
      check_eq("head_taken", 32'(out_inst_taken), 32'(exp_q[0].taken));
    end
  endtask

  task automatic step_model(input bit rb, input bit en, input bit rdy, input bit dec,
                            input bit tk, input logic [31:0] npc, input logic [31:0] data);
    bit   pop, had_room;
    ent_t e;
    if (rb) begin
      exp_q.delete();
      m_req = 1'b0;
      m_fe  = 1'b0;
      return;
    end
    if (!en) return;
    pop      = dec && (exp_q.size() > 0);
    had_room = exp_q.size() < DEPTH;
    if (pop) void'(exp_q.pop_front());
    if (m_fe) begin
      e.inst  = m_last_inst;
      e.pc    = m_last_pc;
      e.taken = tk;
      exp_q.push_back(e);
      m_fe = 1'b0;
    end else if (m_req) begin
      if (rdy) begin
        m_req       = 1'b0;
        m_last_pc   = m_addr;
        m_last_inst = data;
        m_fe        = 1'b1;
      end
    end else if (had_room) begin
      m_req  = 1'b1;
      m_addr = npc;
    end
  endtask

  // One clock: check at the falling edge, then drive inputs for the next rising edge.
  task automatic cycle();
    bit          rb, en, rdy, dec, tk, was_req;
    logic [31:0] data;
    check_outputs();
    if (out_pc_fetcher_ena) fe_cnt++;
    if (spacing_chk && out_mem_req && !prev_req) begin
      if (last_rise >= 0) check_eq("req_spacing", 32'(cyc - last_rise), 32'd5);
      last_rise = cyc;
    end
    prev_req = out_mem_req;

    rdy  = m_req && (mem_cnt >= lat - 1);
    rb   = force_rb || ($urandom_range(99) < rb_pct) || (rb_on_ready && rdy);
    en   = $urandom_range(99) >= ena_low_pct;
    dec  = $urandom_range(99) < dec_pct;
    tk   = rand_taken ? 1'($urandom_range(1)) : (m_last_pc == 32'h10);
    data = rdy ? mem_word(m_addr) : $urandom;

    in_rollback      = rb;
    ena              = en;
    in_mem_ready     = rdy;
    in_mem_data      = data;
    in_decoder_ready = dec;
    in_pc_next_taken = tk;
    in_pc_next_pc    = pc_reg;

    was_req = m_req;
    step_model(rb, en, rdy, dec, tk, pc_reg, data);

    if (m_req && was_req) mem_cnt++;
    else begin
      mem_cnt = 0;
      if (m_req) lat = fixed_lat ? 3 : $urandom_range(4, 1);
    end

    if (rb) pc_reg = rand_pc ? ($urandom & 32'hFFFF_FFFC) : 32'h200;
    else if (rand_pc) pc_reg = $urandom & 32'hFFFF_FFFC;
    else if (m_fe) pc_reg = m_last_pc + 32'd4;

    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; ena = 1'b1; in_rollback = 1'b0; in_pc_next_pc = 32'hDEAD_BEE0;
    in_pc_next_taken = 1'b1; in_mem_ready = 1'b1; in_mem_data = 32'hFFFF_FFFF;
    in_decoder_ready = 1'b1;
    fixed_lat = 1; rb_on_ready = 0; rand_pc = 0; rand_taken = 0; force_rb = 0;
    spacing_chk = 1; dec_pct = 100; rb_pct = 0; ena_low_pct = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_req", 32'(out_mem_req), 32'd0);
    check_eq("rst_fetcher_ena", 32'(out_pc_fetcher_ena), 32'd0);
    check_eq("rst_inst_valid", 32'(out_inst_valid), 32'd0);
    check_eq("rst_mem_addr", out_mem_addr, 32'd0);
    check_eq("rst_inst", out_inst, 32'd0);
    rst = 1'b1;

    // Sequential fetch, latency 3: requests 5 cycles apart, taken only at pc 0x10.
    repeat (30) cycle();
    spacing_chk = 0;

    // Decoder stalled: exactly DEPTH fetches, then no further request.
    force_rb = 1; cycle(); force_rb = 0;
    dec_pct = 0; fe_cnt = 0;
    repeat (40) cycle();
    check_eq("stall_pushes", 32'(fe_cnt), DEPTH);
    check_eq("stall_no_req", 32'(out_mem_req), 32'd0);
    dec_pct = 100; cycle(); dec_pct = 0;

    // Rollback while waiting with 3 entries queued.
    for (int i = 0; i < 20 && !(m_req && exp_q.size() == 3); i++) cycle();
    check_eq("wait_with_3", 32'(m_req && exp_q.size() == 3), 32'd1);
    force_rb = 1; cycle(); force_rb = 0;
    check_eq("flush_valid", 32'(out_inst_valid), 32'd0);
    cycle();
    check_eq("rb_req", 32'(out_mem_req), 32'd1);
    check_eq("rb_addr", out_mem_addr, 32'h200);

    // Rollback coinciding with memory ready and decoder ready.
    rb_on_ready = 1; fixed_lat = 0; dec_pct = 50;
    repeat (300) cycle();
    rb_on_ready = 0;

    // Fully random traffic, including enable gaps.
    rand_pc = 1; rand_taken = 1; rb_pct = 3; ena_low_pct = 15; dec_pct = 60;
    repeat (3000) cycle();

    check_outputs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
# inst_fetcher

Instruction fetch stage between the `pc` unit and the decoder/issue logic. Each fetch cycle reads the next address from `pc` and requests one 32-bit word from the memory controller. The returned instruction is reported back to `pc` so it can compute the next address, then queued together with its prediction bit in an internal FIFO that the decoder drains. On rollback the block flushes everything in flight and restarts from the corrected address.

## Interface
- `QUEUE_DEPTH`, 8: instruction queue entries; must be a power of two and ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset.
- `ena`  in  1  global enable; low freezes all state.
- `in_rollback`  in  1  misbranch flush, driven by `pc.out_rollback`.
- `in_pc_next_pc`  in  32  next fetch address from `pc`.
- `in_pc_next_taken`  in  1  prediction for `out_pc_last_pc`.
- `out_pc_fetcher_ena`  out  1  one-cycle pulse: a new instruction is presented to `pc`.
- `out_pc_last_pc`  out  32  address of the fetched instruction.
- `out_pc_last_inst`  out  32  fetched instruction word.
- `out_mem_req`  out  1  read request.
- `out_mem_addr`  out  32  word address; stable while `out_mem_req` is high.
- `in_mem_ready`  in  1  one-cycle pulse: `in_mem_data` is valid.
- `in_mem_data`  in  32  returned word.
- `out_inst_valid`  out  1  queue not empty.
- `out_inst`, `out_inst_pc`  out  32 each  head entry: instruction word and its address.
- `out_inst_taken`  out  1  head entry prediction bit.
- `in_decoder_ready`  in  1  pops the head entry when `out_inst_valid` is high.

## Operation
- FSM states: `S_ISSUE`, `S_WAIT`, `S_SETTLE`.
- `S_ISSUE`, queue count < `QUEUE_DEPTH`:
  - register `out_mem_req`=1 and `out_mem_addr`=`in_pc_next_pc`.
  - go to `S_WAIT`.
- `S_ISSUE`, queue full: stay in `S_ISSUE`, no request.
- `S_WAIT`: hold the request. On `in_mem_ready`:
  - `out_mem_req`←0.
  - `out_pc_last_pc`←address, `out_pc_last_inst`←`in_mem_data`.
  - `out_pc_fetcher_ena`←1.
  - go to `S_SETTLE`.
- `S_SETTLE` (one cycle; `pc` registers its new next PC during this cycle):
  - push {`out_pc_last_inst`, `out_pc_last_pc`, `in_pc_next_taken`} into the queue.
  - `out_pc_fetcher_ena`←0.
  - go to `S_ISSUE`.
- At most one memory request is outstanding. The space check at `S_ISSUE` guarantees the later push never overflows.
- Queue pop: when `out_inst_valid && in_decoder_ready`. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo `QUEUE_DEPTH`.
- Rollback, any state; takes priority over `ena` and over `in_mem_ready`:
  - queue flushed (count 0, pointers 0).
  - `out_mem_req`←0, `out_pc_fetcher_ena`←0.
  - state←`S_ISSUE`.
  - any pending `S_SETTLE` push is dropped.
  - a pop requested in the same cycle is discarded.
- The memory controller also receives rollback and aborts its transfer, so no stale `in_mem_ready` arrives afterwards.
- `ena` low, no rollback: FSM, queue and all outputs hold their values; `in_mem_ready` and `in_decoder_ready` are ignored.
- Reset (`rst`=0 at a rising edge):
  - all outputs 0.
  - state `S_ISSUE`, queue empty.
  - the first fetch uses `in_pc_next_pc` (0 out of `pc` reset).

## Timing
- All outputs are registered except `out_inst_valid`, `out_inst`, `out_inst_pc`, `out_inst_taken`, which are driven combinationally from the queue head.
- `S_ISSUE` in cycle t → `out_mem_req` high from t+1.
- `in_mem_ready` in cycle k (k ≥ t+1):
  - request low and `out_pc_fetcher_ena` high in k+1.
  - entry visible at the queue head in k+2 if the queue was empty.
  - next request issued in k+3.
- Throughput: one instruction per (memory latency + 2) cycles.
- Rollback asserted in cycle r → first new request in r+2, addressed by `in_pc_next_pc` as seen in cycle r+1.

## Structure
- `DATA_WIDTH`, `ZERO_DATA`, `TRUE`/`FALSE` come from `constant.v`.
- Add `INST_QUEUE_WIDTH` (65 bits: inst + pc + taken) to `constant.v`.
- FSM encodings are module-local localparams.
- One sub-module, `inst_queue`:
  - parameterised synchronous FIFO (`QUEUE_DEPTH`, width 65) with push, pop and flush.
  - outputs empty, full, count.

## Test plan
- Reset, memory with fixed latency 3, `in_pc_next_pc` stepping 0,4,8 → requests at 0,4,8 spaced 5 cycles apart. Queue head shows 0x00000000/inst0, then the following entries in order.
- `in_decoder_ready`=0 for 20 fetches with `QUEUE_DEPTH`=4 → exactly 4 pushes, no 5th request. One pop → the next request starts two cycles after the pop edge.
- `in_pc_next_taken`=1 only while `out_pc_last_pc`=0x10 → only the entry with pc 0x10 has `out_inst_taken`=1.
- Rollback mid-`S_WAIT` with 3 entries queued, `in_pc_next_pc`=0x200 → queue empty next cycle, and the next request is at 0x200 in r+2.
- Rollback in the same cycle as `in_mem_ready` and `in_decoder_ready` → no push, no `out_pc_fetcher_ena` pulse, count 0.
- `ena` low for 5 cycles during `S_WAIT` with an `in_mem_ready` pulse → state, queue and request held, pulse ignored. Operation resumes once `ena` goes high.
